// File: rtl/lsu_pkg.sv
// Shared types and lane-mask helper for the load/store word adapter.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  // Bytes touched by an access; word (and anything else) covers all four lanes.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << lane;
      SZ_H:    m = 4'b0011 << {lane[1], 1'b0};
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane extract/extend for loads and read-modify-write merge for stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [31:0] merge,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  mask;
  logic [31:0] bit_mask;
  logic [31:0] repl;

  always_comb begin
    byte_sel = rdata[8*lane +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    ld_data  = rdata;
    repl     = wdata;
    case (size)
      SZ_B: begin
        ld_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        repl    = {4{wdata[7:0]}};
      end
      SZ_H: begin
        ld_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        repl    = {2{wdata[15:0]}};
      end
      default: begin
        ld_data = rdata;
        repl    = wdata;
      end
    endcase
    mask     = lane_mask(size, lane);
    bit_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    st_data  = (repl & bit_mask) | (merge & ~bit_mask);
  end

endmodule

// File: rtl/lsu_word_adapter.sv
// Turns byte/halfword/word load-store requests into word accesses on a word-only memory.
//   state | meaning
//   IDLE  | ready for a request
//   RD    | memory read: load capture or store merge capture
//   WR    | memory write (one cycle)
//   RESP  | one-cycle completion pulse
module lsu_word_adapter
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              accept;
  logic              req_err;
  logic [31:0]       ld_data;
  logic [31:0]       st_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                            req_err = 1'b1;
    if (req_size == SZ_H && req_addr[0])              req_err = 1'b1;
    if (req_size == SZ_W && req_addr[1:0] != 2'b00)   req_err = 1'b1;
  end

  lsu_byte_lane u_lane (
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .is_unsigned (uns_q),
    .rdata       (mem_rdata),
    .wdata       (wdata_q),
    .merge       (merge_q),
    .ld_data     (ld_data),
    .st_data     (st_data)
  );

  // Gating with rst keeps a reset that lands in WR from corrupting memory.
  assign mem_we     = (state == WR) && !rst;
  assign mem_addr   = (state == RD || state == WR) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata  = (state == WR) ? st_data : 32'h0;
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= 32'h0;
            err_q   <= req_err;
            if (req_err)                          state <= RESP;
            else if (!req_we || req_size != SZ_W) state <= RD;
            else                                  state <= WR;
          end
        end
        RD: begin
          if (we_q) begin
            merge_q <= mem_rdata;
            state   <= WR;
          end else begin
            rdata_q <= ld_data;
            state   <= RESP;
          end
        end
        WR:      state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
